misr_sig_analyzer: RTL

- Parametrised multiple-input signature register (MISR) with a windowed compaction controller and a golden-signature compare.
- BIST response analyser: compacts WIDTH-bit circuit-under-test responses over a programmable number of valid words, then reports pass/fail.
- Successor to the fixed 4-bit MISR, adding:
  - width and polynomial parameters
  - seed load
  - data qualification
  - window counting
  - abort
  - a result flag

---
 rtl/misr_pkg.sv | 16 +
 rtl/misr_core.sv | 42 ++++
 rtl/misr_sig_analyzer.sv | 118 +++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature analyser.
// Holds the controller state encoding and common feedback polynomials.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  localparam logic [3:0]  POLY4  = 4'h3;
  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h1021;
  localparam logic [31:0] POLY32 = 32'h04C11DB7;

endpackage

// File: rtl/misr_core.sv
// Signature register with internal-XOR, left-shift MISR update.
// Load takes priority over compaction.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = POLY16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] fb;

  always_comb begin
    fb    = sig_q[WIDTH-1] ? POLY : '0;
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ fb ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_sig_analyzer.sv
// BIST response analyser: windowed MISR compaction with
// seed load, stall, abort and golden-signature compare.
module misr_sig_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = POLY16,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] win_len,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] golden,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  misr_state_e      state_q;
  misr_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pass_q;
  logic             pass_d;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] sig_cur;
  logic [WIDTH-1:0] sig_nxt;
  logic [WIDTH-1:0] fb;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (load),
    .seed    (seed),
    .en      (en),
    .in_data (in_data),
    .sig     (sig_cur)
  );

  // Look-ahead of the core update so the final compare sees the
  // signature that the last valid word produces.
  always_comb begin
    fb      = sig_cur[WIDTH-1] ? POLY : '0;
    sig_nxt = {sig_cur[WIDTH-2:0], 1'b0} ^ fb ^ in_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          cnt_d  = win_len;
          pass_d = 1'b0;
          if (win_len == '0) begin
            state_d = DONE;
            pass_d  = (seed == golden);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (in_valid) begin
          en    = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            pass_d  = (sig_nxt == golden);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign sig  = sig_cur;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule
